// File: rtl/cpu_seq_param.sv
// cpu_seq_param: parametrised instruction sequencer. Fetches fixed-format
// instructions from an internal synchronous RAM and executes them as APB-style
// peripheral transfers, RAM self-writes, jumps, delays and peripheral resets.
// Instruction layout: [IW-1:IW-3] opcode, next AW bits address, low DW bits data.
module cpu_seq_param #(
  parameter int AW      = 8,
  parameter int DW      = 21,
  parameter int IDEPTH  = 4096,
  parameter int NSEL    = 8,
  parameter int TIMEOUT = 16,
  localparam int PW     = $clog2(IDEPTH),
  localparam int SELW   = $clog2(NSEL),
  localparam int IW     = 3 + AW + DW
) (
  input  logic            clk,
  input  logic            CPURESET,
  input  logic            RUN,
  input  logic            CPUPREADY,
  input  logic [DW-1:0]   CPUPRDATA,
  input  logic            IMWE,
  input  logic [PW-1:0]   IMWADDR,
  input  logic [IW-1:0]   IMWDATA,
  output logic            APBMASTERENABLE,
  output logic [AW-1:0]   CPUADDR,
  output logic [DW-1:0]   CPUDATA,
  output logic            CPUWRITE,
  output logic [NSEL-1:0] CPUSEL,
  output logic [DW-1:0]   CPURDATA,
  output logic            CPUDONE,
  output logic            CPUERR,
  output logic            CPUPERPHRESET,
  output logic [PW-1:0]   PC
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_HALT   = 3'd0;
  localparam logic [2:0] OP_READ   = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_IMW    = 3'd3;
  localparam logic [2:0] OP_WRITE  = 3'd4;
  localparam logic [2:0] OP_WAIT   = 3'd5;
  localparam logic [2:0] OP_PRESET = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SETUP, S_ACCESS,
    S_OPFETCH, S_WAITCNT, S_DONE, S_ERR
  } state_t;

  state_t            state, next_state;
  logic [IW-1:0]     mem [IDEPTH];
  logic [IW-1:0]     ram_q;
  logic              ram_re;
  logic [PW-1:0]     ram_raddr;
  logic [PW-1:0]     pc, pc_next, pc_inc;
  logic [2:0]        dec_op, cur_op;
  logic [AW-1:0]     dec_addr, cur_addr;
  logic [DW-1:0]     dec_data;
  logic [PW-1:0]     imw_addr;
  logic              op_phase;
  logic [DW-1:0]     wait_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              load_bus, capture, commit, bus_active;

  // Fields of the word currently presented by the RAM (valid in DECODE/OPFETCH)
  assign dec_op   = ram_q[IW-1 -: 3];
  assign dec_addr = ram_q[DW +: AW];
  assign dec_data = ram_q[DW-1:0];
  assign pc_inc   = pc + 1'b1;
  assign imw_addr = PW'(cur_addr);

  // Instruction RAM: load port and self-write commit, read-first so a word
  // loaded at the address being fetched only shows up on the next fetch;
  // the load port is written last so it wins an address collision
  always_ff @(posedge clk) begin
    if (commit)
      mem[imw_addr] <= ram_q;
    if (IMWE)
      mem[IMWADDR] <= IMWDATA;
    if (ram_re)
      ram_q <= mem[ram_raddr];
  end

  // State register and program counter
  always_ff @(posedge clk) begin
    if (CPURESET) begin
      state <= S_IDLE;
      pc    <= '0;
    end else begin
      state <= next_state;
      pc    <= pc_next;
    end
  end

  // Next-state, PC update and datapath strobes
  always_comb begin
    next_state = state;
    pc_next    = pc;
    ram_re     = 1'b0;
    ram_raddr  = pc;
    load_bus   = 1'b0;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (RUN)
          next_state = S_FETCH;
      end
      S_FETCH: begin
        ram_re     = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        case (dec_op)
          OP_HALT: next_state = S_DONE;
          OP_READ, OP_WRITE: begin
            load_bus   = 1'b1;
            next_state = S_SETUP;
          end
          OP_JUMP: begin
            pc_next    = PW'(dec_data);
            next_state = RUN ? S_FETCH : S_IDLE;
          end
          OP_IMW: next_state = S_OPFETCH;
          OP_WAIT: begin
            if (dec_data == '0) begin
              pc_next    = pc_inc;
              next_state = RUN ? S_FETCH : S_IDLE;
            end else begin
              next_state = S_WAITCNT;
            end
          end
          OP_PRESET: begin
            pc_next    = pc_inc;
            next_state = RUN ? S_FETCH : S_IDLE;
          end
          default: next_state = S_ERR;
        endcase
      end
      S_SETUP: next_state = S_ACCESS;
      S_ACCESS: begin
        if (CPUPREADY) begin
          capture    = (cur_op == OP_READ);
          pc_next    = pc_inc;
          next_state = RUN ? S_FETCH : S_IDLE;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          next_state = S_ERR;
        end
      end
      S_OPFETCH: begin
        if (!op_phase) begin
          ram_re    = 1'b1;
          ram_raddr = pc_inc;
        end else begin
          commit     = !CPURESET;
          pc_next    = pc + PW'(2);
          next_state = RUN ? S_FETCH : S_IDLE;
        end
      end
      S_WAITCNT: begin
        if (wait_cnt == '0) begin
          pc_next    = pc_inc;
          next_state = RUN ? S_FETCH : S_IDLE;
        end
      end
      S_DONE: begin
        if (!RUN) begin
          pc_next    = '0;
          next_state = S_IDLE;
        end
      end
      S_ERR: next_state = S_ERR;
      default: next_state = S_IDLE;
    endcase
  end

  // Latched instruction, bus registers, read capture and cycle counters
  always_ff @(posedge clk) begin
    if (CPURESET) begin
      cur_op   <= '0;
      cur_addr <= '0;
      CPUADDR  <= '0;
      CPUDATA  <= '0;
      CPURDATA <= '0;
      op_phase <= 1'b0;
      wait_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (state == S_DECODE) begin
        cur_op   <= dec_op;
        cur_addr <= dec_addr;
      end
      if (load_bus) begin
        CPUADDR <= dec_addr;
        CPUDATA <= dec_data;
      end
      if (capture)
        CPURDATA <= CPUPRDATA;
      op_phase <= (state == S_OPFETCH) && !op_phase;
      if (state == S_DECODE)
        wait_cnt <= dec_data - 1'b1;
      else if (state == S_WAITCNT)
        wait_cnt <= wait_cnt - 1'b1;
      tmo_cnt <= (state == S_ACCESS) ? tmo_cnt + 1'b1 : '0;
    end
  end

  // Bus strobes and status flags decoded from the current state
  always_comb begin
    bus_active      = (state == S_SETUP) || (state == S_ACCESS);
    APBMASTERENABLE = (state == S_ACCESS);
    CPUWRITE        = bus_active && (cur_op == OP_WRITE);
    CPUDONE         = (state == S_DONE);
    CPUERR          = (state == S_ERR);
    CPUPERPHRESET   = (state == S_DECODE) && (dec_op == OP_PRESET);
    CPUSEL          = '0;
    if (bus_active)
      CPUSEL[CPUADDR[AW-1 -: SELW]] = 1'b1;
  end

  assign PC = pc;

endmodule

// File: tb/tb_cpu_seq_param.sv
// tb_cpu_seq_param: table-driven APB transfer vectors with a transfer
// scoreboard, plus hand-written sequences for self-write, timeout, wait,
// reset abort and PC wrap on a small-RAM instance.
module tb_cpu_seq_param;

  localparam logic [2:0] OP_HALT   = 3'd0;
  localparam logic [2:0] OP_READ   = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_IMW    = 3'd3;
  localparam logic [2:0] OP_WRITE  = 3'd4;
  localparam logic [2:0] OP_WAIT   = 3'd5;
  localparam logic [2:0] OP_PRESET = 3'd6;
  localparam logic [2:0] OP_BAD    = 3'd7;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  addr;
    logic [20:0] data;
    int          w;
    logic [20:0] prdata;
    logic [7:0]  exp_sel;
    logic [20:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [20:0] data;
    logic        write;
    logic [7:0]  sel;
  } xfer_t;

  typedef struct {
    int          done_cyc;
    int          acc;
    int          perph;
    int          perph_cyc;
    logic        err;
    logic [11:0] pc;
    logic [20:0] rdata;
  } res_t;

  logic        clk = 1'b0;
  logic        CPURESET, RUN, CPUPREADY, IMWE;
  logic [20:0] CPUPRDATA;
  logic [11:0] IMWADDR;
  logic [31:0] IMWDATA;
  logic        APBMASTERENABLE, CPUWRITE, CPUDONE, CPUERR, CPUPERPHRESET;
  logic [7:0]  CPUADDR, CPUSEL;
  logic [20:0] CPUDATA, CPURDATA;
  logic [11:0] PC;

  logic        rst8, run8, imwe8;
  logic [2:0]  imwaddr8;
  logic [31:0] imwdata8;
  logic        en8, write8, done8, err8, prst8;
  logic [7:0]  addr8, sel8;
  logic [20:0] data8, rdata8;
  logic [2:0]  pc8;

  int    checks = 0;
  int    failures = 0;
  xfer_t sb[$];
  vec_t  vecs[5];
  res_t  r;

  always #5 clk = ~clk;

  cpu_seq_param dut (
    .clk(clk), .CPURESET(CPURESET), .RUN(RUN), .CPUPREADY(CPUPREADY),
    .CPUPRDATA(CPUPRDATA), .IMWE(IMWE), .IMWADDR(IMWADDR), .IMWDATA(IMWDATA),
    .APBMASTERENABLE(APBMASTERENABLE), .CPUADDR(CPUADDR), .CPUDATA(CPUDATA),
    .CPUWRITE(CPUWRITE), .CPUSEL(CPUSEL), .CPURDATA(CPURDATA),
    .CPUDONE(CPUDONE), .CPUERR(CPUERR), .CPUPERPHRESET(CPUPERPHRESET), .PC(PC)
  );

  cpu_seq_param #(.IDEPTH(8)) dut8 (
    .clk(clk), .CPURESET(rst8), .RUN(run8), .CPUPREADY(1'b1),
    .CPUPRDATA(21'h0), .IMWE(imwe8), .IMWADDR(imwaddr8), .IMWDATA(imwdata8),
    .APBMASTERENABLE(en8), .CPUADDR(addr8), .CPUDATA(data8),
    .CPUWRITE(write8), .CPUSEL(sel8), .CPURDATA(rdata8),
    .CPUDONE(done8), .CPUERR(err8), .CPUPERPHRESET(prst8), .PC(pc8)
  );

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [7:0] a,
                                     input logic [20:0] d);
    return {op, a, d};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    CPURESET = 1'b1;
    @(negedge clk);
    CPURESET = 1'b0;
  endtask

  task automatic loadWord(input int a, input logic [31:0] w);
    IMWE = 1'b1;
    IMWADDR = 12'(a);
    IMWDATA = w;
    @(negedge clk);
    IMWE = 1'b0;
  endtask

  task automatic loadWord8(input int a, input logic [31:0] w);
    imwe8 = 1'b1;
    imwaddr8 = 3'(a);
    imwdata8 = w;
    @(negedge clk);
    imwe8 = 1'b0;
  endtask

  // Runs the main DUT until DONE or ERR; ACCESS completes after w wait cycles
  // and each completion is compared against the head of the scoreboard.
  task automatic runProgram(input int w, input int budget, output res_t res);
    int    acc;
    xfer_t e;
    acc = 0;
    res = '{-1, 0, 0, -1, 1'b0, 12'h0, 21'h0};
    CPUPREADY = 1'b0;
    RUN = 1'b1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (CPUPERPHRESET) begin
        res.perph++;
        res.perph_cyc = cyc;
      end
      if (CPUDONE || CPUERR) begin
        res.done_cyc = cyc;
        res.err = CPUERR;
        res.pc = PC;
        res.rdata = CPURDATA;
        break;
      end
      if (APBMASTERENABLE) begin
        acc++;
        res.acc++;
        CPUPREADY = (acc > w);
        if (CPUPREADY) begin
          acc = 0;
          checkOutput("sb_nonempty", (sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("xfer_sel", CPUSEL, e.sel);
            checkOutput("xfer_addr", CPUADDR, e.addr);
            checkOutput("xfer_data", CPUDATA, e.data);
            checkOutput("xfer_write", CPUWRITE, e.write);
          end
        end
      end else begin
        CPUPREADY = 1'b0;
      end
    end
    RUN = 1'b0;
    CPUPREADY = 1'b0;
    checkOutput("run_bound", (res.done_cyc >= 0), 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    doReset();
    loadWord(0, mk(v.op, v.addr, v.data));
    loadWord(1, mk(OP_HALT, 8'h0, 21'h0));
    sb.push_back('{v.addr, v.data, (v.op == OP_WRITE), v.exp_sel});
    CPUPRDATA = v.prdata;
    runProgram(v.w, 200, r);
    checkOutput("vec_done_cycle", r.done_cyc, 6 + v.w);
    checkOutput("vec_access_cycles", r.acc, v.w + 1);
    checkOutput("vec_pc", r.pc, 12'd1);
    checkOutput("vec_rdata", r.rdata, v.exp_rdata);
    checkOutput("vec_err", r.err, 0);
    checkOutput("vec_sb_empty", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  pulses;
    int  done_c;
    logic found;
    CPURESET = 1'b1; RUN = 1'b0; CPUPREADY = 1'b0; CPUPRDATA = '0;
    IMWE = 1'b0; IMWADDR = '0; IMWDATA = '0;
    rst8 = 1'b1; run8 = 1'b0; imwe8 = 1'b0; imwaddr8 = '0; imwdata8 = '0;
    vecs[0] = '{OP_WRITE, 8'h21, 21'h3,      0,  21'h0,     8'h02, 21'h0};
    vecs[1] = '{OP_READ,  8'hE0, 21'h0,      3,  21'h1ABCD, 8'h80, 21'h1ABCD};
    vecs[2] = '{OP_WRITE, 8'h5A, 21'h1FFFFF, 1,  21'h7,     8'h04, 21'h0};
    vecs[3] = '{OP_WRITE, 8'hC3, 21'h12345,  15, 21'h0,     8'h40, 21'h0};
    vecs[4] = '{OP_READ,  8'h7F, 21'h0,      0,  21'h00055, 8'h08, 21'h00055};
    @(negedge clk);
    @(negedge clk);
    CPURESET = 1'b0;
    rst8 = 1'b0;

    for (int i = 0; i < 5; i++)
      applyStimulus(vecs[i]);

    // Reset after a captured read clears every output
    doReset();
    checkOutput("rst_rdata", CPURDATA, 0);
    checkOutput("rst_addr_data", {CPUADDR, CPUDATA}, 0);
    checkOutput("rst_sel", CPUSEL, 0);
    checkOutput("rst_ctl", {APBMASTERENABLE, CPUWRITE, CPUDONE, CPUERR, CPUPERPHRESET}, 0);
    checkOutput("rst_pc", PC, 0);

    // Self-write: copy word 1 into word 15, jump there and execute it
    loadWord(0, mk(OP_IMW, 8'h0F, 21'h0));
    loadWord(1, mk(OP_WRITE, 8'h21, 21'hF));
    loadWord(2, mk(OP_JUMP, 8'h0, 21'd15));
    loadWord(15, mk(OP_BAD, 8'h0, 21'h0));
    loadWord(16, mk(OP_HALT, 8'h0, 21'h0));
    sb.push_back('{8'h21, 21'hF, 1'b1, 8'h02});
    runProgram(0, 200, r);
    checkOutput("imw_done_cycle", r.done_cyc, 12);
    checkOutput("imw_err", r.err, 0);
    checkOutput("imw_pc", r.pc, 12'd16);
    checkOutput("imw_sb_empty", sb.size(), 0);
    @(negedge clk);
    checkOutput("done_to_idle_pc", PC, 0);

    // Access timeout with CPUPREADY held low
    doReset();
    loadWord(0, mk(OP_WRITE, 8'h21, 21'h5));
    runProgram(1000, 200, r);
    checkOutput("tmo_err", r.err, 1);
    checkOutput("tmo_access_cycles", r.acc, 16);
    checkOutput("tmo_pc", r.pc, 0);
    @(negedge clk);
    checkOutput("tmo_err_held", CPUERR, 1);
    checkOutput("tmo_bus_idle", {APBMASTERENABLE, CPUWRITE, CPUSEL}, 0);
    doReset();
    checkOutput("tmo_err_cleared", CPUERR, 0);

    // WAIT 5 then PRESET then HALT
    loadWord(0, mk(OP_WAIT, 8'h0, 21'd5));
    loadWord(1, mk(OP_PRESET, 8'h0, 21'h0));
    loadWord(2, mk(OP_HALT, 8'h0, 21'h0));
    runProgram(0, 200, r);
    checkOutput("wait_done_cycle", r.done_cyc, 11);
    checkOutput("wait_pc", r.pc, 12'd2);
    checkOutput("preset_pulses", r.perph, 1);
    checkOutput("preset_cycle", r.perph_cyc, 8);
    @(negedge clk);

    // Reset during ACCESS aborts the read with no capture
    doReset();
    loadWord(0, mk(OP_READ, 8'hE0, 21'h0));
    CPUPRDATA = 21'h12345;
    CPUPREADY = 1'b0;
    RUN = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (APBMASTERENABLE) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("abort_reached_access", found, 1);
    CPURESET = 1'b1;
    CPUPREADY = 1'b1;
    @(negedge clk);
    CPURESET = 1'b0;
    CPUPREADY = 1'b0;
    RUN = 1'b0;
    checkOutput("abort_sel", CPUSEL, 0);
    checkOutput("abort_en", APBMASTERENABLE, 0);
    checkOutput("abort_rdata", CPURDATA, 0);
    checkOutput("abort_pc", PC, 0);

    // Small RAM: IMEM_WRITE at the last word wraps to word 0 for its operand
    loadWord8(0, mk(OP_PRESET, 8'h0, 21'h0));
    loadWord8(1, mk(OP_JUMP, 8'h0, 21'd7));
    loadWord8(3, mk(OP_BAD, 8'h0, 21'h0));
    loadWord8(4, mk(OP_HALT, 8'h0, 21'h0));
    loadWord8(7, mk(OP_IMW, 8'h03, 21'h0));
    pulses = 0;
    run8 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (prst8) pulses++;
      if (c == 5) run8 = 1'b0;
    end
    checkOutput("wrap_pc", pc8, 3'd1);
    checkOutput("wrap_pulses", pulses, 1);
    checkOutput("wrap_err", err8, 0);
    loadWord8(1, mk(OP_JUMP, 8'h0, 21'd3));
    pulses = 0;
    done_c = -1;
    run8 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (prst8) pulses++;
      if (done8 || err8) begin
        done_c = c;
        break;
      end
    end
    run8 = 1'b0;
    checkOutput("wrap_run_done_cycle", done_c, 6);
    checkOutput("wrap_written_word_ran", pulses, 1);
    checkOutput("wrap_run_err", err8, 0);
    checkOutput("wrap_run_pc", pc8, 3'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_seq_param.md
# cpu_seq_param

Parametrised instruction sequencer that fetches fixed-format instructions from an internal instruction RAM and executes them as APB-style peripheral transfers, RAM self-writes, jumps, delays and peripheral resets. It is the next generation of the team's simple processor. Compared with that processor it adds:
- configurable address/data width, RAM depth and select count;
- APB reads with captured read data;
- jump and wait opcodes;
- an access timeout with an error state;
- an explicit RAM load port for benches and boot logic, replacing hierarchical pokes.

## Interface
Parameters:
- AW, 8: transfer address width.
- DW, 21: transfer data width.
- IDEPTH, 4096: instruction RAM depth in words; must be a power of 2. PW = clog2(IDEPTH).
- NSEL, 8: peripheral select count; must be a power of 2 and ≥2. SELW = clog2(NSEL).
- TIMEOUT, 16: maximum ACCESS cycles allowed without CPUPREADY.
- Instruction width IW = 3+AW+DW (32 by default). Fields: [IW-1:IW-3] opcode, next AW bits addr, low DW bits data.

Ports:
- clk  in  1  clock; all logic on rising edge.
- CPURESET  in  1  one clock; reset is synchronous and active-high.
- RUN  in  1  start/continue execution.
- CPUPREADY  in  1  peripheral ready, sampled in ACCESS.
- CPUPRDATA  in  DW  peripheral read data, captured when ACCESS completes a read.
- IMWE  in  1  RAM load strobe.
- IMWADDR  in  PW  RAM load address.
- IMWDATA  in  IW  RAM load data.
- APBMASTERENABLE  out  1  enable strobe; high in ACCESS only.
- CPUADDR  out  AW  transfer address.
- CPUDATA  out  DW  write data.
- CPUWRITE  out  1  1 = write, 0 = read.
- CPUSEL  out  NSEL  one-hot select, decoded from CPUADDR[AW-1 -: SELW].
- CPURDATA  out  DW  last captured read data.
- CPUDONE  out  1  high in DONE.
- CPUERR  out  1  high in ERR.
- CPUPERPHRESET  out  1  one-cycle peripheral reset pulse.
- PC  out  PW  program counter.

## Operation
- Opcodes:
  - 000 HALT: go to DONE.
  - 001 APB_READ.
  - 010 JUMP: PC <= data[PW-1:0].
  - 011 IMEM_WRITE: the next RAM word is written to RAM[addr[PW-1:0]]; PC advances by 2.
  - 100 APB_WRITE.
  - 101 WAIT: stall data cycles; 0 means no stall.
  - 110 PRESET: CPUPERPHRESET pulses high for 1 cycle.
  - 111 illegal: go to ERR.
- States: IDLE, FETCH, DECODE, SETUP, ACCESS, OPFETCH, WAITCNT, DONE, ERR.
- IDLE: leaves to FETCH when RUN=1.
- FETCH: issues RAM read at PC; synchronous RAM, 1-cycle read latency.
- DECODE: latches the instruction.
  - APB ops go to SETUP.
  - IMEM_WRITE goes to FETCH of word PC+1 via OPFETCH.
  - WAIT goes to WAITCNT.
  - JUMP, PRESET and NOP-like completions return to FETCH, or to IDLE if RUN=0.
- SETUP: CPUSEL, CPUADDR, CPUDATA and CPUWRITE are driven; APBMASTERENABLE=0. Always 1 cycle, then ACCESS.
- ACCESS: APBMASTERENABLE=1; the bus outputs hold stable.
  - CPUPREADY=1: transfer completes; a read captures CPURDATA <= CPUPRDATA; PC+1; next state FETCH, or IDLE if RUN=0.
  - CPUPREADY low for TIMEOUT consecutive ACCESS cycles: go to ERR.
- DONE: CPUDONE=1. When RUN=0: go to IDLE and PC <= 0.
- ERR: CPUERR=1 and PC frozen at the faulting instruction. Exit only by CPURESET.
- PC arithmetic is modulo IDEPTH: PC=IDEPTH-1 increments to 0. An IMEM_WRITE at IDEPTH-1 takes its operand from word 0.
- RAM load port: IMWE writes in any state.
  - If it collides with an IMEM_WRITE commit to the same address in the same cycle, the load port wins.
  - A word loaded at the current PC during FETCH is seen only from the next FETCH.
- CPUSEL, APBMASTERENABLE and CPUWRITE are 0 outside SETUP/ACCESS. CPUADDR and CPUDATA keep their last values.

## Timing
- Reset: state IDLE and PC=0. Every output is 0, including CPURDATA, CPUSEL, CPUDONE, CPUERR and CPUPERPHRESET. RAM contents are unchanged.
- CPURESET mid-transfer aborts it: outputs are 0 in the cycle after reset is sampled, and there is no capture.
- APB op with CPUPREADY already high: 4 cycles (FETCH, DECODE, SETUP, ACCESS). Each wait cycle adds 1.
- IMEM_WRITE: 4 cycles, with the RAM commit at the end of the 4th.
- JUMP, PRESET and HALT: 2 cycles. WAIT n: 2+n cycles.
- RUN is sampled only at instruction boundaries. RUN=0 mid-instruction lets that instruction finish.
- Timeout boundary: CPUPREADY on the TIMEOUT-th ACCESS cycle completes normally; ERR is entered only if it is still low at that edge.

## Test plan
- Load RAM[0]=APB_WRITE addr 0x21 data 0x3, RAM[1]=HALT; CPUPREADY high -> CPUSEL=0x02, APBMASTERENABLE high for 1 cycle, CPUDONE high at cycle 6, PC=1.
- RAM[0]=APB_READ addr 0xE0; CPUPREADY low 3 cycles, then high with CPUPRDATA=0x1ABCD -> CPUSEL=0x80, ACCESS lasts 4 cycles, CPURDATA=0x1ABCD.
- RAM[0]=IMEM_WRITE addr 0x0F, RAM[1]=APB_WRITE data 0xF, RAM[2]=JUMP 0x0F -> RAM[15] holds the written word, which then executes with CPUDATA=0xF.
- APB_WRITE with CPUPREADY held low -> CPUERR=1 after exactly 16 ACCESS cycles, PC=0, outputs idle; CPURESET clears CPUERR.
- IDEPTH=8: RAM[7]=IMEM_WRITE addr 3, RAM[0]=PRESET word -> RAM[3] written, PC wraps to 1; separately, WAIT 5 stalls 5 cycles and PRESET pulses CPUPERPHRESET for 1 cycle.
- CPURESET asserted during ACCESS -> CPUSEL and APBMASTERENABLE are 0 the next cycle, CPURDATA stays 0, PC=0.
